pipe_en_ctrl: RTL and testbench

Flow controller for a linear chain of enable-gated data registers (the enable/reset register primitive in `common/rtl`). It tracks a valid bit per stage, accepts beats on a valid/ready slave port, presents them on a valid/ready master port, and drives one load-enable per stage. Back-pressure collapses bubbles, so only stalled stages hold. The datapath registers live outside this block; it sequences only their `en_i`.

---
 rtl/pipe_en_ctrl.sv | 79 +++++++
 tb/tb_pipe_en_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_en_ctrl.sv
// Flow controller for a chain of enable-gated data registers: tracks per-stage
// valid bits, collapses bubbles under back-pressure and drives one load enable per stage.
module pipe_en_ctrl #(
    parameter int Stages = 4,
    parameter int CntW   = $clog2(Stages + 1)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    input  logic              flush_i,
    output logic [Stages-1:0] en_o,
    output logic [Stages-1:0] vld_o,
    output logic [CntW-1:0]   count_o,
    output logic              idle_o
);

    logic [Stages-1:0] vld_reg;
    logic [Stages-1:0] vld_next;
    logic [Stages-1:0] rdy;
    logic [Stages-1:0] vin;
    logic [CntW-1:0]   cnt_reg;
    logic [CntW-1:0]   cnt_next;
    logic              hold_off;
    logic              accept;
    logic              deliver;

    // Nothing may load while reset is held or the pipe is being flushed.
    assign hold_off = ~rstn_i | flush_i;

    // Ready ripples from the output back towards stage 0.
    always_comb begin
        rdy = '0;
        rdy[Stages-1] = ~vld_reg[Stages-1] | m_ready_i;
        for (int i = Stages - 2; i >= 0; i--) begin
            rdy[i] = ~vld_reg[i] | rdy[i+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Stages; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign vin[gi] = s_valid_i;
            end else begin : g_rest
                assign vin[gi] = vld_reg[gi-1];
            end
            // Load only when a real beat moves in, so held stages keep their data.
            assign en_o[gi]     = rdy[gi] & vin[gi] & ~hold_off;
            assign vld_next[gi] = rdy[gi] ? vin[gi] : vld_reg[gi];
        end
    endgenerate

    assign s_ready_o = rdy[0] & ~hold_off;
    assign m_valid_o = vld_reg[Stages-1];
    assign accept    = s_valid_i & s_ready_o;
    assign deliver   = m_valid_o & m_ready_i;
    assign cnt_next  = cnt_reg + CntW'(accept) - CntW'(deliver);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vld_reg <= '0;
            cnt_reg <= '0;
        end else if (flush_i) begin
            vld_reg <= '0;
            cnt_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            cnt_reg <= cnt_next;
        end
    end

    assign vld_o   = vld_reg;
    assign count_o = cnt_reg;
    assign idle_o  = (cnt_reg == '0);

endmodule

// File: tb/tb_pipe_en_ctrl.sv
// Self-checking bench for pipe_en_ctrl: directed vectors with literal expectations
// plus a per-cycle comparison against a beat-position model of the pipe.
module tb_pipe_en_ctrl;
    localparam int S = 4;
    localparam int CW = $clog2(S + 1);

    logic          clk;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic          flush;
    logic [S-1:0]  en;
    logic [S-1:0]  vld;
    logic [CW-1:0] count;
    logic          idle;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_en_ctrl #(.Stages(S)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .flush_i  (flush),
        .en_o     (en),
        .vld_o    (vld),
        .count_o  (count),
        .idle_o   (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each in-flight beat is tracked by its stage position, oldest first.
    // A beat advances one stage per cycle unless the beat ahead of it still
    // occupies the next stage after its own move; the oldest leaves from the
    // last stage when downstream is ready.
    int  mpos[$];
    int  mnext[$];
    bit  chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [S-1:0] vexp;
            logic [S-1:0] enexp;
            logic         srexp;
            int           prev;
            int           np;
            vexp  = '0;
            enexp = '0;
            mnext.delete();
            foreach (mpos[k]) vexp[mpos[k]] = 1'b1;
            if (!rstn || flush) begin
                srexp = 1'b0;
            end else begin
                prev = S;
                foreach (mpos[k]) begin
                    if (mpos[k] == S - 1) np = m_ready ? S : mpos[k];
                    else np = (prev > mpos[k] + 1) ? mpos[k] + 1 : mpos[k];
                    if (np < S) begin
                        mnext.push_back(np);
                        if (np != mpos[k]) enexp[np] = 1'b1;
                    end
                    prev = np;
                end
                srexp = (mnext.size() == 0) ? 1'b1 : (mnext[mnext.size()-1] != 0);
                if (s_valid && srexp) begin
                    enexp[0] = 1'b1;
                    mnext.push_back(0);
                end
            end
            chk("model_vld", 32'(vld), 32'(vexp));
            chk("model_en", 32'(en), 32'(enexp));
            chk("model_s_ready", 32'(s_ready), 32'(srexp));
            chk("model_m_valid", 32'(m_valid), 32'(vexp[S-1]));
            chk("model_count", 32'(count), 32'(mpos.size()));
            chk("count_le_stages", 32'(count <= CW'(S)), 32'd1);
            chk("count_popcount", 32'(count), 32'($countones(vld)));
            chk("idle_inv", 32'(idle), 32'(count == '0));
        end
    end

    always @(posedge clk) begin
        if (!chk_en) begin
            mpos.delete();
            chk_en = 1'b1;
        end else begin
            mpos = mnext;
        end
    end

    // Drive inputs just after a rising edge and let combinational outputs settle.
    task automatic set(input logic sv, input logic mr, input logic fl, input logic rn);
        s_valid = sv;
        m_ready = mr;
        flush   = fl;
        rstn    = rn;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [S-1:0] stream_en [8];
        stream_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        s_valid = 1'b1;
        m_ready = 1'b1;
        flush   = 1'b0;
        rstn    = 1'b0;

        // Reset state
        adv();
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);

        // Streaming, 8 beats back to back
        for (int k = 0; k < 8; k++) begin
            set(1'b1, 1'b1, 1'b0, 1'b1);
            chk("stream_en", 32'(en), 32'(stream_en[k]));
            chk("stream_s_ready", 32'(s_ready), 32'd1);
            adv();
            chk("stream_count", 32'(count), (k < 3) ? 32'(k + 1) : 32'd4);
            chk("stream_m_valid", 32'(m_valid), 32'(k >= 3));
        end
        set(1'b0, 1'b1, 1'b0, 1'b1);
        chk("drain_en", 32'(en), 32'b1110);
        for (int k = 0; k < 4; k++) begin
            set(1'b0, 1'b1, 1'b0, 1'b1);
            adv();
            chk("drain_count", 32'(count), 32'(3 - k));
        end
        chk("drain_idle", 32'(idle), 32'd1);

        // Fill and stall
        for (int k = 0; k < 4; k++) begin
            set(1'b1, 1'b0, 1'b0, 1'b1);
            chk("fill_s_ready", 32'(s_ready), 32'd1);
            chk("fill_en", 32'(en), 32'((1 << (k + 1)) - 1));
            adv();
        end
        set(1'b1, 1'b0, 1'b0, 1'b1);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_en", 32'(en), 32'd0);
        adv();
        chk("full_count", 32'(count), 32'd4);
        set(1'b1, 1'b1, 1'b0, 1'b1);
        chk("release_s_ready", 32'(s_ready), 32'd1);
        chk("release_en", 32'(en), 32'b1111);
        adv();
        chk("release_count", 32'(count), 32'd4);

        // Flush with three beats in flight
        set(1'b0, 1'b1, 1'b0, 1'b1);
        adv();
        chk("preflush_count", 32'(count), 32'd3);
        set(1'b1, 1'b0, 1'b1, 1'b1);
        chk("flush_s_ready", 32'(s_ready), 32'd0);
        chk("flush_en", 32'(en), 32'd0);
        adv();
        set(1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_vld", 32'(vld), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_idle", 32'(idle), 32'd1);
        chk("postflush_s_ready", 32'(s_ready), 32'd1);

        // Bubble collapse
        set(1'b1, 1'b0, 1'b0, 1'b1);
        adv();
        set(1'b0, 1'b0, 1'b0, 1'b1);
        adv();
        set(1'b1, 1'b0, 1'b0, 1'b1);
        chk("bubble_en0", 32'(en), 32'b0101);
        adv();
        chk("bubble_vld0", 32'(vld), 32'b0101);
        set(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bubble_en1", 32'(en), 32'b1010);
        adv();
        chk("bubble_vld1", 32'(vld), 32'b1010);
        chk("bubble_en2", 32'(en), 32'b0100);
        adv();
        chk("bubble_vld2", 32'(vld), 32'b1100);
        chk("bubble_count", 32'(count), 32'd2);
        chk("bubble_en3", 32'(en), 32'd0);

        // Reset mid-stream with the pipe full
        set(1'b1, 1'b0, 1'b0, 1'b1);
        adv();
        adv();
        chk("prerst_count", 32'(count), 32'd4);
        set(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        adv();
        chk("midrst_vld", 32'(vld), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        set(1'b1, 1'b1, 1'b0, 1'b1);
        adv();
        for (int k = 0; k < 4; k++) begin
            set(1'b0, 1'b1, 1'b0, 1'b1);
            chk("resume_m_valid", 32'(m_valid), 32'(k == 3));
            adv();
        end

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 10000; k++) begin
            set(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) < 6),
                1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 255) != 0));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
